// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: turns a simple req/gnt host port into TL-UL A/D traffic.
// It keeps up to MaxReqs transactions outstanding and returns their responses
// in order as one-cycle valid pulses with registered data and error status.

package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;
endpackage

package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef logic [7:0] tl_a_user_t;
  typedef logic [7:0] tl_d_user_t;
  localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic                          a_valid;
    tl_a_op_e                      a_opcode;
    logic [2:0]                    a_param;
    logic [top_pkg::TL_SZW-1:0]    a_size;
    logic [top_pkg::TL_AIW-1:0]    a_source;
    logic [top_pkg::TL_AW-1:0]     a_address;
    logic [top_pkg::TL_DBW-1:0]    a_mask;
    logic [top_pkg::TL_DW-1:0]     a_data;
    tl_a_user_t                    a_user;
    logic                          d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                          d_valid;
    tl_d_op_e                      d_opcode;
    logic [2:0]                    d_param;
    logic [top_pkg::TL_SZW-1:0]    d_size;
    logic [top_pkg::TL_AIW-1:0]    d_source;
    logic [top_pkg::TL_DIW-1:0]    d_sink;
    logic [top_pkg::TL_DW-1:0]     d_data;
    tl_d_user_t                    d_user;
    logic                          d_error;
    logic                          a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_adapter #(
  parameter int MaxReqs = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              unexp_rsp_o,
  output tlul_pkg::tl_h2d_t tl_o,
  input  tlul_pkg::tl_d2h_t tl_i
);

  localparam int CW  = $clog2(MaxReqs + 1);
  localparam int SW  = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam int AIW = top_pkg::TL_AIW;
  localparam logic [CW-1:0] CntMax = CW'(MaxReqs);
  localparam logic [SW-1:0] IdxMax = SW'(MaxReqs - 1);

  logic [CW-1:0]              cnt;
  logic [SW-1:0]              sid, wptr, rptr;
  logic [MaxReqs-1:0][SW-1:0] fifo_sid;
  logic [MaxReqs-1:0]         fifo_we;

  logic          a_valid, push, pop, d_unexp;
  logic [SW-1:0] head_sid;
  logic          head_we, src_err, op_err;

  logic          valid_q, err_q, unexp_q;
  logic [31:0]   rdata_q;

  // Fields of the D channel this host never looks at.
  logic unused_d;
  assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

  // Source ids and FIFO pointers both count modulo MaxReqs.
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] p);
    return (p == IdxMax) ? '0 : SW'(p + 1'b1);
  endfunction

  // Handshake decode and FIFO head check.
  always_comb begin
    a_valid  = req_i & (cnt != CntMax);
    push     = a_valid & tl_i.a_ready;
    pop      = tl_i.d_valid & (cnt != '0);
    d_unexp  = tl_i.d_valid & (cnt == '0);
    head_sid = fifo_sid[rptr];
    head_we  = fifo_we[rptr];
    src_err  = (tl_i.d_source != AIW'(head_sid));
    op_err   = head_we ? (tl_i.d_opcode != tlul_pkg::AccessAck)
                       : (tl_i.d_opcode != tlul_pkg::AccessAckData);
  end

  // A-channel request fields, purely combinational from the host port.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = !we_i          ? tlul_pkg::Get :
                     (be_i == 4'hF) ? tlul_pkg::PutFullData :
                                      tlul_pkg::PutPartialData;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = AIW'(sid);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask    = we_i ? be_i : 4'hF;
    tl_o.a_data    = we_i ? wdata_i : 32'h0;
    tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  // Outstanding count, source id and FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt  <= '0;
      sid  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push) begin
        sid  <= wrap_inc(sid);
        wptr <= wrap_inc(wptr);
      end
      if (pop) rptr <= wrap_inc(rptr);
    end
  end

  // Tracking storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_sid[wptr] <= sid;
      fifo_we[wptr]  <= we_i;
    end
  end

  // Response register: one-cycle valid pulse, data and error held until next.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      valid_q <= pop;
      if (pop) begin
        rdata_q <= (tl_i.d_opcode == tlul_pkg::AccessAckData) ? tl_i.d_data : 32'h0;
        err_q   <= tl_i.d_error | src_err | op_err;
      end
      if (d_unexp) unexp_q <= 1'b1;
    end
  end

  assign gnt_o       = push;
  assign busy_o      = (cnt != '0);
  assign valid_o     = valid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter (MaxReqs=2): a per-cycle vector table
// plus a short hand-written stall/response sequence with bounded waits.

module tb_tlul_host_adapter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req, gnt, we, valid, err, busy, unexp;
  logic [31:0]       addr, wdata, rdata;
  logic [3:0]        be;
  tlul_pkg::tl_h2d_t tl_o;
  tlul_pkg::tl_d2h_t tl_i;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tlul_host_adapter #(.MaxReqs(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .be_i(be), .valid_o(valid), .rdata_o(rdata),
    .err_o(err), .busy_o(busy), .unexp_rsp_o(unexp), .tl_o(tl_o), .tl_i(tl_i)
  );

  typedef struct {
    logic        rst_n, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        a_ready;
    logic        d_valid, d_ackdata;
    logic [7:0]  d_src;
    logic [31:0] d_data;
    logic        d_err;
    logic        gnt, av;
    logic [2:0]  op;
    logic [7:0]  src;
    logic [31:0] a_addr;
    logic [3:0]  mask;
    logic [31:0] a_data;
    logic        busy, valid;
    logic [31:0] rdata;
    logic        err, unexp;
  } vec_t;

  localparam int NV = 27;
  localparam logic L = 1'b0, H = 1'b1;
  localparam logic [2:0] OG = 3'h4, OF = 3'h0, OP = 3'h1;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst_n        = v.rst_n;
    req          = v.req;
    we           = v.we;
    addr         = v.addr;
    wdata        = v.wdata;
    be           = v.be;
    tl_i         = '0;
    tl_i.a_ready = v.a_ready;
    tl_i.d_valid = v.d_valid;
    tl_i.d_opcode = v.d_ackdata ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
    tl_i.d_source = v.d_src;
    tl_i.d_data  = v.d_data;
    tl_i.d_error = v.d_err;
  endtask

  task automatic compare(input int i, input vec_t v);
    chk($sformatf("r%0d gnt", i),    32'(gnt), 32'(v.gnt));
    chk($sformatf("r%0d a_valid", i), 32'(tl_o.a_valid), 32'(v.av));
    chk($sformatf("r%0d a_opcode", i), 32'(tl_o.a_opcode), 32'(v.op));
    chk($sformatf("r%0d a_source", i), 32'(tl_o.a_source), 32'(v.src));
    chk($sformatf("r%0d a_address", i), tl_o.a_address, v.a_addr);
    chk($sformatf("r%0d a_mask", i), 32'(tl_o.a_mask), 32'(v.mask));
    chk($sformatf("r%0d a_data", i), tl_o.a_data, v.a_data);
    chk($sformatf("r%0d busy", i),   32'(busy), 32'(v.busy));
    chk($sformatf("r%0d valid", i),  32'(valid), 32'(v.valid));
    chk($sformatf("r%0d rdata", i),  rdata, v.rdata);
    chk($sformatf("r%0d err", i),    32'(err), 32'(v.err));
    chk($sformatf("r%0d unexp", i),  32'(unexp), 32'(v.unexp));
  endtask

  initial begin
    // Columns: rst,req,we,addr,wdata,be,a_ready | d_valid,ackdata,d_src,d_data,d_err |
    //          gnt,a_valid,op,src,a_addr,mask,a_data | busy,valid,rdata,err,unexp
    // single read of 0x1003, then AccessAckData
    vecs[0]  = '{H,H,L,32'h1003,32'h55,4'h0,H, L,L,8'h0,32'h0,L, H,H,OG,8'h0,32'h1000,4'hF,32'h0, L,L,32'h0,L,L};
    vecs[1]  = '{H,L,L,32'h0,32'h0,4'h0,H, H,H,8'h0,32'hDEADBEEF,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, H,L,32'h0,L,L};
    vecs[2]  = '{H,L,L,32'h0,32'h0,4'h0,H, L,L,8'h0,32'h0,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, L,H,32'hDEADBEEF,L,L};
    vecs[3]  = '{L,L,L,32'h0,32'h0,4'h0,H, L,L,8'h0,32'h0,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, L,L,32'hDEADBEEF,L,L};
    // two writes fill the window, third request held off
    vecs[4]  = '{H,H,H,32'h2000,32'h11111111,4'hF,H, L,L,8'h0,32'h0,L, H,H,OF,8'h0,32'h2000,4'hF,32'h11111111, L,L,32'h0,L,L};
    vecs[5]  = '{H,H,H,32'h2004,32'h22222222,4'hF,H, L,L,8'h0,32'h0,L, H,H,OF,8'h1,32'h2004,4'hF,32'h22222222, H,L,32'h0,L,L};
    vecs[6]  = '{H,H,L,32'h3000,32'h0,4'h0,H, L,L,8'h0,32'h0,L, L,L,OG,8'h0,32'h3000,4'hF,32'h0, H,L,32'h0,L,L};
    // response at full: request still held that cycle
    vecs[7]  = '{H,H,L,32'h3000,32'h0,4'h0,H, H,L,8'h0,32'h0,L, L,L,OG,8'h0,32'h3000,4'hF,32'h0, H,L,32'h0,L,L};
    // accept and response together at cnt=1
    vecs[8]  = '{H,H,L,32'h3000,32'h0,4'h0,H, H,L,8'h1,32'h0,L, H,H,OG,8'h0,32'h3000,4'hF,32'h0, H,H,32'h0,L,L};
    vecs[9]  = '{H,L,L,32'h0,32'h0,4'h0,H, H,H,8'h0,32'hCAFEF00D,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, H,H,32'h0,L,L};
    // partial write, response carrying d_error
    vecs[10] = '{H,H,H,32'h4006,32'hAABBCCDD,4'h3,H, L,L,8'h0,32'h0,L, H,H,OP,8'h1,32'h4004,4'h3,32'hAABBCCDD, L,H,32'hCAFEF00D,L,L};
    vecs[11] = '{H,L,L,32'h0,32'h0,4'h0,H, H,L,8'h1,32'h0,H, L,L,OG,8'h0,32'h0,4'hF,32'h0, H,L,32'hCAFEF00D,L,L};
    // unexpected response with nothing outstanding
    vecs[12] = '{H,L,L,32'h0,32'h0,4'h0,H, H,H,8'h0,32'h12345678,L, L,L,OG,8'h0,32'h0,4'hF,32'h0, L,H,32'h0,H,L};
    // a_ready low: offered but not granted
    vecs[13] = '{H,H,L,32'h5000,32'h0,4'h0,L, L,L,8'h0,32'h0,L, L,H,OG,8'h0,32'h5000,4'hF,32'h0, L,L,32'h0,H,H};
    vecs[14] = '{H,H,L,32'h5000,32'h0,4'h0,H, L,L,8'h0,32'h0,L, H,H,OG,8'h0,32'h5000,4'hF,32'h0, L,L,32'h0,H,H};
    vecs[15] = '{H,L,L,32'h0,32'h0,4'h0,H, H,H,8'h0,32'h0BADF00D,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, H,L,32'h0,H,H};
    // read answered with AccessAck: opcode mismatch
    vecs[16] = '{H,H,L,32'h6000,32'h0,4'h0,H, L,L,8'h0,32'h0,L, H,H,OG,8'h1,32'h6000,4'hF,32'h0, L,H,32'h0BADF00D,L,H};
    vecs[17] = '{H,L,L,32'h0,32'h0,4'h0,H, H,L,8'h1,32'h0,L, L,L,OG,8'h0,32'h0,4'hF,32'h0, H,L,32'h0BADF00D,L,H};
    // clean write response clears err
    vecs[18] = '{H,H,H,32'h7000,32'h77,4'hF,H, L,L,8'h0,32'h0,L, H,H,OF,8'h0,32'h7000,4'hF,32'h77, L,H,32'h0,H,H};
    vecs[19] = '{H,L,L,32'h0,32'h0,4'h0,H, H,L,8'h0,32'h0,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, H,L,32'h0,H,H};
    // two outstanding, then reset
    vecs[20] = '{H,H,H,32'h7004,32'h88,4'hF,H, L,L,8'h0,32'h0,L, H,H,OF,8'h1,32'h7004,4'hF,32'h88, L,H,32'h0,L,H};
    vecs[21] = '{H,H,L,32'h8000,32'h0,4'h0,H, L,L,8'h0,32'h0,L, H,H,OG,8'h0,32'h8000,4'hF,32'h0, H,L,32'h0,L,H};
    vecs[22] = '{L,L,L,32'h0,32'h0,4'h0,H, L,L,8'h0,32'h0,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, H,L,32'h0,L,H};
    // late response after reset is unexpected
    vecs[23] = '{H,L,L,32'h0,32'h0,4'h0,H, H,H,8'h0,32'h99,L, L,L,OG,8'h0,32'h0,4'hF,32'h0, L,L,32'h0,L,L};
    // first request after reset uses source 0; answer with wrong source
    vecs[24] = '{H,H,L,32'h9000,32'h0,4'h0,H, L,L,8'h0,32'h0,L, H,H,OG,8'h0,32'h9000,4'hF,32'h0, L,L,32'h0,L,H};
    vecs[25] = '{H,L,L,32'h0,32'h0,4'h0,H, H,H,8'h1,32'h1234,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, H,L,32'h0,L,H};
    vecs[26] = '{H,L,L,32'h0,32'h0,4'h0,H, L,L,8'h0,32'h0,L, L,L,OG,8'h1,32'h0,4'hF,32'h0, L,H,32'h1234,H,H};

    // reset state
    drive(vecs[3]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst valid", 32'(valid), 32'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst unexp", 32'(unexp), 32'h0);
    chk("rst a_valid", 32'(tl_o.a_valid), 32'h0);
    chk("d_ready", 32'(tl_o.d_ready), 32'h1);
    chk("a_size", 32'(tl_o.a_size), 32'h2);
    chk("a_param", 32'(tl_o.a_param), 32'h0);
    chk("a_user", 32'(tl_o.a_user), 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      compare(i, vecs[i]);
    end

    // Hand sequence: stalled read (a_ready low), then granted and answered.
    // State here: cnt=0, sid=1.
    begin
      logic got;
      @(posedge clk); #1;
      drive(vecs[26]);
      req = 1'b1; addr = 32'hA000; tl_i.a_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("stall gnt", 32'(gnt), 32'h0);
        chk("stall a_valid", 32'(tl_o.a_valid), 32'h1);
        @(posedge clk);
      end
      #1 tl_i.a_ready = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (gnt) begin got = 1'b1; break; end
      end
      chk("hs gnt seen", 32'(got), 32'h1);
      chk("hs a_source", 32'(tl_o.a_source), 32'h1);
      @(posedge clk); #1;
      req = 1'b0;
      tl_i.d_valid  = 1'b1;
      tl_i.d_opcode = tlul_pkg::AccessAckData;
      tl_i.d_source = 8'h1;
      tl_i.d_data   = 32'hA5A5A5A5;
      @(posedge clk); #1;
      tl_i.d_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (valid) begin got = 1'b1; break; end
      end
      chk("hs valid seen", 32'(got), 32'h1);
      chk("hs rdata", rdata, 32'hA5A5A5A5);
      chk("hs err", 32'(err), 32'h0);
      chk("hs busy", 32'(busy), 32'h0);
      @(negedge clk);
      chk("hs pulse end", 32'(valid), 32'h0);
      chk("hs rdata held", rdata, 32'hA5A5A5A5);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
